// File: rtl/pc_sequencer.sv
// Fetch-stage program-counter generator with flush/branch/return/jump selection and a return-address stack.
// Optional macro PC_ALIGN_CHECK_EN adds a registered next-PC misalignment flag.
module pc_sequencer #(
  parameter int                ADDR_W    = 32,
  parameter int                INC       = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_i,
  input  logic              imem_ready_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] flush_pc_i,
  input  logic              br_taken_i,
  input  logic [ADDR_W-1:0] br_target_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_target_i,
  input  logic              call_i,
  input  logic [ADDR_W-1:0] call_link_i,
  input  logic              ret_i,
  input  logic [ADDR_W-1:0] ret_fallback_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [ADDR_W-1:0] pc_plus_o,
  output logic              pc_valid_o,
  output logic              ras_empty_o,
  output logic              ras_full_o,
  output logic              misalign_o
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              valid_q;
  logic [PTR_W-1:0]  top_q, top_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

  logic              adv, id_en, push, pop;
  logic              ras_we;
  logic [PTR_W-1:0]  ras_waddr;
  logic              ras_empty, ras_full;
  logic [ADDR_W-1:0] ras_top;

  assign adv       = valid_q & ~stall_i & imem_ready_i;
  assign id_en     = adv & ~flush_i & ~br_taken_i;
  assign push      = id_en & call_i;
  assign pop       = id_en & ret_i;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ras_top   = ras_q[top_q];

  assign pc_o        = pc_q;
  assign pc_plus_o   = pc_q + ADDR_W'(INC);
  assign pc_valid_o  = valid_q;
  assign ras_empty_o = ras_empty;
  assign ras_full_o  = ras_full;

  always_comb begin
    pc_d = pc_q;
    if (flush_i)         pc_d = flush_pc_i;
    else if (br_taken_i) pc_d = br_target_i;
    else if (pop)        pc_d = ras_empty ? ret_fallback_i : ras_top;
    else if (id_en && jump_i) pc_d = jump_target_i;
    else if (adv)        pc_d = pc_plus_o;
  end

  // Simultaneous call+return replaces the top entry in place instead of pop-then-push.
  always_comb begin
    ras_we    = 1'b0;
    ras_waddr = top_q;
    top_d     = top_q;
    cnt_d     = cnt_q;
    if (push && pop) begin
      ras_we = 1'b1;
      if (ras_empty) cnt_d = CNT_W'(1);
    end else if (push) begin
      ras_we    = 1'b1;
      ras_waddr = top_q + PTR_W'(1);
      top_d     = top_q + PTR_W'(1);
      if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !ras_empty) begin
      top_d = top_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      valid_q <= 1'b0;
      top_q   <= '0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= 1'b1;
      top_q   <= top_d;
      cnt_q   <= cnt_d;
    end
  end

  // Entries are only meaningful below the count, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (ras_we) ras_q[ras_waddr] <= call_link_i;
  end

`ifdef PC_ALIGN_CHECK_EN
  logic misalign_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= |(pc_d & ADDR_W'(INC - 1));
  end
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: queue-based reference model checked every cycle plus literal checkpoints.
module tb_pc_sequencer;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall_i = 0, imem_ready_i = 1, flush_i = 0, br_taken_i = 0;
  logic        jump_i = 0, call_i = 0, ret_i = 0;
  logic [31:0] flush_pc_i = 0, br_target_i = 0, jump_target_i = 0;
  logic [31:0] call_link_i = 0, ret_fallback_i = 0;
  logic [31:0] pc_o, pc_plus_o;
  logic        pc_valid_o, ras_empty_o, ras_full_o, misalign_o;

  int vectors = 0;
  int miscompares = 0;

  pc_sequencer #(.ADDR_W(32), .INC(4), .RESET_VEC(32'h0), .RAS_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .imem_ready_i(imem_ready_i),
    .flush_i(flush_i), .flush_pc_i(flush_pc_i), .br_taken_i(br_taken_i),
    .br_target_i(br_target_i), .jump_i(jump_i), .jump_target_i(jump_target_i),
    .call_i(call_i), .call_link_i(call_link_i), .ret_i(ret_i),
    .ret_fallback_i(ret_fallback_i), .pc_o(pc_o), .pc_plus_o(pc_plus_o),
    .pc_valid_o(pc_valid_o), .ras_empty_o(ras_empty_o), .ras_full_o(ras_full_o),
    .misalign_o(misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC, valid flag and the return stack as a queue (newest at back).
  logic [31:0] m_pc = 0;
  logic        m_valid = 0;
  logic        m_mis = 0;
  logic [31:0] m_ras[$];

  always @(posedge clk or negedge rst_n) begin
    logic        adv, id_ok;
    logic [31:0] npc;
    if (!rst_n) begin
      m_pc = 0; m_valid = 0; m_mis = 0; m_ras.delete();
    end else begin
      adv   = m_valid && !stall_i && imem_ready_i;
      id_ok = adv && !flush_i && !br_taken_i;
      if (flush_i)                npc = flush_pc_i;
      else if (br_taken_i)        npc = br_target_i;
      else if (id_ok && ret_i)    npc = (m_ras.size() == 0) ? ret_fallback_i : m_ras[m_ras.size()-1];
      else if (id_ok && jump_i)   npc = jump_target_i;
      else if (adv)               npc = m_pc + 32'd4;
      else                        npc = m_pc;
      if (id_ok && call_i && ret_i) begin
        if (m_ras.size() == 0) m_ras.push_back(call_link_i);
        else m_ras[m_ras.size()-1] = call_link_i;
      end else if (id_ok && call_i) begin
        m_ras.push_back(call_link_i);
        if (m_ras.size() > D) void'(m_ras.pop_front());
      end else if (id_ok && ret_i) begin
        if (m_ras.size() != 0) void'(m_ras.pop_back());
      end
`ifdef PC_ALIGN_CHECK_EN
      m_mis = |npc[1:0];
`endif
      m_pc = npc;
      m_valid = 1;
    end
  end

  always @(negedge clk) begin
    chk("pc_o", pc_o, m_pc);
    chk("pc_plus_o", pc_plus_o, m_pc + 32'd4);
    chk("pc_valid_o", {31'b0, pc_valid_o}, {31'b0, m_valid});
    chk("ras_empty_o", {31'b0, ras_empty_o}, {31'b0, m_ras.size() == 0});
    chk("ras_full_o", {31'b0, ras_full_o}, {31'b0, m_ras.size() == D});
    chk("misalign_o", {31'b0, misalign_o}, {31'b0, m_mis});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall_i = 0; imem_ready_i = 1; flush_i = 0; br_taken_i = 0;
    jump_i = 0; call_i = 0; ret_i = 0;
  endtask

  initial begin
    ret_fallback_i = 32'hF00;
    step(); step();
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_valid", {31'b0, pc_valid_o}, 32'd0);
    chk("rst_empty", {31'b0, ras_empty_o}, 32'd1);
    chk("rst_full", {31'b0, ras_full_o}, 32'd0);
    chk("rst_mis", {31'b0, misalign_o}, 32'd0);
    rst_n = 1;
    step(); chk("first_pc", pc_o, 32'h0); chk("first_valid", {31'b0, pc_valid_o}, 32'd1);
    step(); chk("seq1", pc_o, 32'h4);
    step(); chk("seq2", pc_o, 32'h8);

    // Address wrap
    flush_i = 1; flush_pc_i = 32'hFFFF_FFFC;
    step(); chk("wrap_pre", pc_o, 32'hFFFF_FFFC); chk("wrap_plus", pc_plus_o, 32'h0);
    idle();
    step(); chk("wrap_pc", pc_o, 32'h0); chk("wrap_plus2", pc_plus_o, 32'h4);

    // Stall blocks jump; branch overrides stall
    stall_i = 1; jump_i = 1; jump_target_i = 32'h300;
    step(); chk("stall_hold", pc_o, 32'h0);
    jump_i = 0; br_taken_i = 1; br_target_i = 32'h100;
    step(); chk("br_in_stall", pc_o, 32'h100);
    idle();

    // Flush beats branch
    flush_i = 1; flush_pc_i = 32'h80; br_taken_i = 1; br_target_i = 32'h200;
    step(); chk("flush_prio", pc_o, 32'h80);
    idle();

    // Unready memory holds PC and ignores call
    imem_ready_i = 0; call_i = 1; call_link_i = 32'hAA;
    step(); chk("notready_hold", pc_o, 32'h80); chk("notready_empty", {31'b0, ras_empty_o}, 32'd1);
    idle();

    // Five calls overflow a depth-4 stack
    for (int i = 1; i <= 5; i++) begin
      call_i = 1; call_link_i = 32'(i * 16);
      step();
    end
    chk("calls_pc", pc_o, 32'h94); chk("calls_full", {31'b0, ras_full_o}, 32'd1);
    call_i = 0; ret_i = 1;
    step(); chk("ret1", pc_o, 32'h50);
    step(); chk("ret2", pc_o, 32'h40);
    step(); chk("ret3", pc_o, 32'h30);
    step(); chk("ret4", pc_o, 32'h20); chk("ret4_empty", {31'b0, ras_empty_o}, 32'd1);
    step(); chk("ret5_fb", pc_o, 32'hF00);
    idle();

    // Call and return together
    call_i = 1; call_link_i = 32'h10; step();
    call_link_i = 32'h20; step();
    ret_i = 1; call_link_i = 32'h60;
    step(); chk("cr_pc", pc_o, 32'h20); chk("cr_empty", {31'b0, ras_empty_o}, 32'd0);
    call_i = 0;
    step(); chk("cr_ret1", pc_o, 32'h60);
    step(); chk("cr_ret2", pc_o, 32'h10);
    step(); chk("cr_ret3", pc_o, 32'hF00);
    call_i = 1; call_link_i = 32'h77;
    step(); chk("cr_empty_pc", pc_o, 32'hF00); chk("cr_empty_cnt", {31'b0, ras_empty_o}, 32'd0);
    call_i = 0;
    step(); chk("cr_empty_ret", pc_o, 32'h77);
    idle();

    // Branch suppresses ID-stage call/return/jump
    call_i = 1; call_link_i = 32'h99; br_taken_i = 1; br_target_i = 32'h400;
    step(); chk("br_nocall", pc_o, 32'h400); chk("br_nocall_empty", {31'b0, ras_empty_o}, 32'd1);
    idle();
    jump_i = 1; jump_target_i = 32'h500;
    step(); chk("jump", pc_o, 32'h500);
    idle();

    // Mid-operation reset
    call_i = 1; call_link_i = 32'h123; step(); idle();
    rst_n = 0; #1;
    chk("mid_rst_pc", pc_o, 32'h0);
    chk("mid_rst_valid", {31'b0, pc_valid_o}, 32'd0);
    chk("mid_rst_empty", {31'b0, ras_empty_o}, 32'd1);
    step();
    rst_n = 1;
    step(); chk("post_rst_pc", pc_o, 32'h0);
    step(); chk("post_rst_seq", pc_o, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
